// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, constants and helpers for the data-memory
//               responder (state encoding, transfer sizes, size decoding).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Two-state controller, explicitly encoded.
    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE   = 1'b0;
    localparam state_t c_ST_ACCESS = 1'b1;

    // Legal transfer sizes in bytes.
    localparam logic [3:0] c_SZ_B = 4'd1;
    localparam logic [3:0] c_SZ_H = 4'd2;
    localparam logic [3:0] c_SZ_W = 4'd4;
    localparam logic [3:0] c_SZ_D = 4'd8;

    function automatic logic is_legal_size(input logic [3:0] xfer_size);
        return (xfer_size == c_SZ_B) || (xfer_size == c_SZ_H) ||
               (xfer_size == c_SZ_W) || (xfer_size == c_SZ_D);
    endfunction

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [2:0] align_mask(input logic [3:0] xfer_size);
        case (xfer_size)
            c_SZ_H:  return 3'b001;
            c_SZ_W:  return 3'b011;
            c_SZ_D:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // One bit per byte of the transfer, starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [3:0] xfer_size);
        case (xfer_size)
            c_SZ_B:  return 8'h01;
            c_SZ_H:  return 8'h03;
            c_SZ_W:  return 8'h0F;
            c_SZ_D:  return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_lanes.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_lanes
// Description : Combinational byte steering for one 64-bit storage word:
//               byte-enable mask, store data shifted onto its lanes, and
//               load data shifted down to lane 0 and zero-extended.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_lanes
    import dmem_pkg::*;
(
    input  logic [2:0]  i_addr_lo,
    input  logic [3:0]  i_size,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rword,
    output logic [7:0]  o_byte_en,
    output logic [63:0] o_wword,
    output logic [63:0] o_rdata
);

    logic [5:0]  w_shift;
    logic [7:0]  w_len_mask;
    logic [63:0] w_rshift;

    // Accesses are aligned, so the whole transfer lives inside one word.
    always_comb begin
        w_shift    = {i_addr_lo, 3'b000};
        w_len_mask = size_mask(i_size);
        o_byte_en  = w_len_mask << i_addr_lo;
        o_wword    = i_wdata << w_shift;
        w_rshift   = i_rword >> w_shift;
    end

    // Keep only the bytes belonging to the transfer; upper bytes read as zero.
    for (genvar k = 0; k < 8; k++) begin : g_rd_lane
        assign o_rdata[8*k +: 8] = w_len_mask[k] ? w_rshift[8*k +: 8] : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data-memory responder for the CPU load/store
//               port. Validates a request in IDLE, holds busy for LATENCY
//               cycles, then commits the store or returns the load data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic [63:0] read_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        err
);

    localparam int         c_WORDS    = 2 ** (ADDR_BITS - 3);
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_count;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [63:0]           r_wdata;
    logic [3:0]            r_size;
    logic                  r_is_store;
    logic [63:0]           r_read_data;
    logic                  r_rd_valid;
    logic                  r_err;
    logic [63:0]           r_mem [c_WORDS];

    logic                  w_any;
    logic                  w_ok;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_done;
    logic [ADDR_BITS-4:0]  w_idx;
    logic [7:0]            w_byte_en;
    logic [63:0]           w_wword;
    logic [63:0]           w_rword;
    logic [63:0]           w_rdata;

    // Request qualification; an aligned, in-range start address implies the
    // whole transfer fits inside storage.
    always_comb begin
        w_any    = read_enable | write_enable;
        w_ok     = !(read_enable && write_enable) &&
                   is_legal_size(xfer_size) &&
                   ((address[2:0] & align_mask(xfer_size)) == 3'b000) &&
                   (address[63:ADDR_BITS] == '0);
        w_accept = (r_state == c_ST_IDLE) && w_any && w_ok;
        w_reject = (r_state == c_ST_IDLE) && w_any && !w_ok;
        w_done   = (r_state == c_ST_ACCESS) && (r_count == 4'd0);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_nxt = c_ST_ACCESS;
            c_ST_ACCESS: if (w_done)   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Latency counter, pulses and load result; reset aborts any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= 4'd0;
            r_err       <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_read_data <= 64'd0;
        end else begin
            r_err      <= w_reject;
            r_rd_valid <= w_done && !r_is_store;
            if (w_accept)
                r_count <= c_CNT_LOAD;
            else if ((r_state == c_ST_ACCESS) && (r_count != 4'd0))
                r_count <= r_count - 4'd1;
            if (w_done && !r_is_store)
                r_read_data <= w_rdata;
        end
    end

    // Request latch; live inputs are ignored once the access is running.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr     <= address[ADDR_BITS-1:0];
            r_wdata    <= write_data;
            r_size     <= xfer_size;
            r_is_store <= write_enable;
        end
    end

    assign w_idx   = r_addr[ADDR_BITS-1:3];
    assign w_rword = r_mem[w_idx];

    dmem_byte_lanes u_lanes (
        .i_addr_lo (r_addr[2:0]),
        .i_size    (r_size),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_byte_en (w_byte_en),
        .o_wword   (w_wword),
        .o_rdata   (w_rdata)
    );

    // Store commit on completion; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (rst && w_done && r_is_store) begin
            for (int k = 0; k < 8; k++) begin
                if (w_byte_en[k]) r_mem[w_idx][8*k +: 8] <= w_wword[8*k +: 8];
            end
        end
    end

    assign busy      = (r_state == c_ST_ACCESS);
    assign read_data = r_read_data;
    assign rd_valid  = r_rd_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A LATENCY=3 instance
//               is driven through a request task with a load-data scoreboard;
//               a LATENCY=1 instance covers back-to-back loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [63:0] address = '0, write_data = '0, read_data;
    logic        write_enable = 1'b0, read_enable = 1'b0;
    logic [3:0]  xfer_size = 4'd0;
    logic        rd_valid, busy, err;

    logic [63:0] address1 = '0, write_data1 = '0, read_data1;
    logic        write_enable1 = 1'b0, read_enable1 = 1'b0;
    logic [3:0]  xfer_size1 = 4'd0;
    logic        rd_valid1, busy1, err1;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] sb_q[$];
    logic [7:0]  mdl [0:1023];
    logic [63:0] mdl_last = '0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(10), .LATENCY(c_LAT)) u_dut (
        .clk(clk), .rst(rst), .address(address), .write_enable(write_enable),
        .read_enable(read_enable), .write_data(write_data), .xfer_size(xfer_size),
        .read_data(read_data), .rd_valid(rd_valid), .busy(busy), .err(err)
    );

    dmem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .address(address1), .write_enable(write_enable1),
        .read_enable(read_enable1), .write_data(write_data1), .xfer_size(xfer_size1),
        .read_data(read_data1), .rd_valid(rd_valid1), .busy(busy1), .err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_load(input logic [63:0] a, input logic [3:0] sz);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < int'(sz); k++) r[8*k +: 8] = mdl[a[9:0] + 10'(k)];
        return r;
    endfunction

    // Scoreboard: every load completion must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (rst && rd_valid) begin
            chk("rdv_err_excl", {63'd0, err}, 64'd0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rdv", {63'd0, rd_valid}, 64'd0);
            end else begin
                mdl_last = sb_q.pop_front();
                chk("sb_rdata", read_data, mdl_last);
            end
        end
    end

    // Drive one request (inputs valid at the next edge), then check handshake.
    task automatic do_req(input string tag, input logic we, input logic re,
                          input logic [63:0] a, input logic [63:0] d,
                          input logic [3:0] sz, input bit exp_err,
                          input logic [63:0] exp_rd, input bit scramble);
        int n;
        address = a; write_data = d; xfer_size = sz;
        write_enable = we; read_enable = re;
        if (!exp_err && re) sb_q.push_back(exp_rd);
        if (!exp_err && we)
            for (int k = 0; k < int'(sz); k++) mdl[a[9:0] + 10'(k)] = d[8*k +: 8];
        @(posedge clk); #1;
        if (exp_err) begin
            chk({tag, "_err"},   {63'd0, err},  64'd1);
            chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
            chk({tag, "_rdata"}, read_data, mdl_last);
            write_enable = 1'b0; read_enable = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_err_1cyc"}, {63'd0, err}, 64'd0);
            return;
        end
        chk({tag, "_noerr"}, {63'd0, err}, 64'd0);
        if (scramble) begin
            address = a + 64'd8; write_data = 64'hBEEF;
        end else begin
            write_enable = 1'b0; read_enable = 1'b0;
        end
        n = 0;
        while (busy && n < 32) begin
            n++;
            @(posedge clk); #1;
        end
        write_enable = 1'b0; read_enable = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(c_LAT));
        chk({tag, "_rdata_after"}, read_data, re ? exp_rd : mdl_last);
    endtask

    initial begin
        logic [63:0] ld_a  [4];
        logic [3:0]  ld_sz [4];
        logic [63:0] ld_e  [4];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {63'd0, busy},     64'd0);
        chk("rst_err",   {63'd0, err},      64'd0);
        chk("rst_rdv",   {63'd0, rd_valid}, 64'd0);
        chk("rst_rdata", read_data,         64'd0);
        rst = 1'b1;

        do_req("st_d", 1, 0, 64'h10, 64'h1122334455667788, 4'd8, 0, 0, 0);
        do_req("ld_d", 0, 1, 64'h10, 0, 4'd8, 0, 64'h1122334455667788, 0);
        do_req("ld_b", 0, 1, 64'h13, 0, 4'd1, 0, 64'h55, 0);
        do_req("ld_h", 0, 1, 64'h12, 0, 4'd2, 0, 64'h5566, 0);
        do_req("st_b", 1, 0, 64'h11, 64'hFFFF_FFFF_FFFF_FFAB, 4'd1, 0, 0, 0);
        do_req("ld_d2", 0, 1, 64'h10, 0, 4'd8, 0, 64'h112233445566AB88, 0);

        do_req("e_misal", 0, 1, 64'h12,  0, 4'd4, 1, 0, 0);
        do_req("e_size3", 0, 1, 64'h10,  0, 4'd3, 1, 0, 0);
        do_req("e_range", 0, 1, 64'h400, 0, 4'd8, 1, 0, 0);
        do_req("e_both",  1, 1, 64'h10,  0, 4'd8, 1, 0, 0);
        do_req("e_misd",  1, 0, 64'h3FC, 0, 4'd8, 1, 0, 0);

        do_req("pre28", 1, 0, 64'h28, 64'h0102030405060708, 4'd8, 0, 0, 0);
        do_req("st20",  1, 0, 64'h20, 64'hDEAD, 4'd8, 0, 0, 1);
        do_req("ld20",  0, 1, 64'h20, 0, 4'd8, 0, 64'hDEAD, 0);
        do_req("ld28",  0, 1, 64'h28, 0, 4'd8, 0, 64'h0102030405060708, 0);
        do_req("ld_w",  0, 1, 64'h2C, 0, 4'd4, 0, exp_load(64'h2C, 4'd4), 0);

        // Aborted store: reset asserted during the second busy cycle.
        do_req("pre30", 1, 0, 64'h30, 64'h5A5A5A5A5A5A5A5A, 4'd8, 0, 0, 0);
        address = 64'h30; write_data = 64'h1234; xfer_size = 4'd8; write_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        chk("abort_busy_on", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mdl_last = '0;
        chk("abort_busy_off", {63'd0, busy}, 64'd0);
        chk("abort_rdata",    read_data,     64'd0);
        chk("abort_rdv",      {63'd0, rd_valid}, 64'd0);
        do_req("ld30", 0, 1, 64'h30, 0, 4'd8, 0, 64'h5A5A5A5A5A5A5A5A, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        // LATENCY=1 instance: one store, then loads on every free edge.
        address1 = 64'h0; write_data1 = 64'hCAFEF00D12345678; xfer_size1 = 4'd8;
        write_enable1 = 1'b1;
        @(posedge clk); #1;
        write_enable1 = 1'b0;
        chk("l1_st_busy", {63'd0, busy1}, 64'd1);
        @(posedge clk); #1;
        chk("l1_st_idle", {63'd0, busy1}, 64'd0);
        ld_a = '{64'h0, 64'h4, 64'h2, 64'h7};
        ld_sz = '{4'd8, 4'd4, 4'd2, 4'd1};
        ld_e = '{64'hCAFEF00D12345678, 64'hCAFEF00D, 64'h1234, 64'hCA};
        read_enable1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address1 = ld_a[i]; xfer_size1 = ld_sz[i];
            @(posedge clk); #1;
            chk("l1_busy", {63'd0, busy1},     64'd1);
            chk("l1_rdv0", {63'd0, rd_valid1}, 64'd0);
            @(posedge clk); #1;
            chk("l1_rdv1",  {63'd0, rd_valid1}, 64'd1);
            chk("l1_rdata", read_data1,         ld_e[i]);
            chk("l1_err",   {63'd0, err1},      64'd0);
        end
        read_enable1 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder.
- Serves the pipelined CPU's load/store port: address, write_enable, read_enable, write_data, xfer_size in; read_data out.
- Adds a busy/stall handshake so the memory stage can be backed by a slow memory.
- Sits after the EX/MEM register. busy drives the pipeline stall. rd_valid qualifies load data into MEM/WB.

Parameters:
- ADDR_BITS, 10, byte-address width of internal storage (2**ADDR_BITS bytes).
- LATENCY, 3, cycles busy per accepted access (legal range 1..15).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset. Synchronous, active-low: rst=0 at a posedge resets.
- address  input  64  byte address of request.
- write_enable  input  1  store request.
- read_enable  input  1  load request.
- write_data  input  64  store data, little-endian, low bytes used.
- xfer_size  input  4  bytes to transfer; legal values 1, 2, 4, 8.
- read_data  output  64  load result, zero-extended, registered.
- rd_valid  output  1  one-cycle pulse: read_data updated this cycle.
- busy  output  1  access in progress; CPU must stall and hold inputs.
- err  output  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, busy=0, rd_valid=0, err=0, read_data=0.
  - Storage contents are not cleared.
- States:
  - IDLE: ready; busy=0.
  - ACCESS: counting; busy=1.
- Request: sampled at a posedge in IDLE with exactly one of read_enable/write_enable high.
- Validation at the sampling edge. Reject if any of:
  - both enables high;
  - xfer_size not in {1,2,4,8};
  - address not a multiple of xfer_size;
  - address + xfer_size > 2**ADDR_BITS (upper 64-ADDR_BITS bits must be zero).
- Rejected request: err=1 for the next cycle only. State stays IDLE. No storage or read_data change.
- Accepted request:
  - Latch address[ADDR_BITS-1:0], write_data, xfer_size and direction.
  - Load count=LATENCY-1 and go to ACCESS.
- In ACCESS:
  - Each posedge with count!=0 decrements count.
  - At the posedge with count==0, complete and return to IDLE.
- Completion of a store: write bytes addr..addr+size-1 from write_data[8*size-1:0], byte k = write_data[8k+7:8k].
- Completion of a load:
  - read_data = bytes addr..addr+size-1, little-endian, upper bytes 0.
  - rd_valid=1 for one cycle.
- Timing: a request accepted at edge E0 gives busy=1 for exactly LATENCY cycles, falling after edge E0+LATENCY. read_data and rd_valid appear after that same edge.
- Back-to-back: a new request may be sampled at the first edge with busy=0, i.e. E0+LATENCY+1. No dead cycle beyond that.
- Inputs while busy=1 are ignored. Latched values are used, not live inputs.
- read_data holds its value until the next load completes. Stores and errors do not change it.
- Reset mid-ACCESS:
  - Abort the access: no store commit, no rd_valid, read_data=0.
  - Return to IDLE.
- err and rd_valid are never high in the same cycle.
- Enables both low in IDLE: no action.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, ACCESS};
  - size constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8;
  - function is_legal_size(xfer_size).
- Sub-module dmem_byte_lanes (combinational):
  - from latched addr[2:0] and size, produces an 8-bit byte-enable mask;
  - also produces aligned write/read byte steering.
- Top holds the FSM, counter, latches and storage array.

Test Plan:
- Reset, then store addr=0x10, size=8, data=0x1122334455667788, LATENCY=3 -> busy high 3 cycles, err=0. Load addr=0x10, size=8 -> rd_valid after 3 busy cycles, read_data=0x1122334455667788.
- Byte/half access on that data -> load addr=0x13 size=1 returns 0x55; load addr=0x12 size=2 returns 0x5566. Store 0xAB to addr 0x11 size=1, then load 0x10 size=8 -> 0x112233445566AB88.
- Misaligned load addr=0x12 size=4; size=3; address=0x400 with ADDR_BITS=10; both enables high -> each gives err pulse 1 cycle, busy stays 0, read_data unchanged.
- Inputs changed while busy: store addr=0x20 data=0xDEAD, then during busy drive address=0x28 and data=0xBEEF -> load 0x20 returns 0xDEAD, load 0x28 returns prior contents.
- rst=0 during cycle 2 of a store to 0x30 data=0x1234 -> busy=0 next cycle, later load 0x30 returns old value, rd_valid not pulsed by the aborted op.
- LATENCY=1 back-to-back loads on consecutive free edges -> rd_valid every second cycle, correct data each.
